// File: rtl/serializador_if.sv
// Word handshake and serial output bundle of the serializador.
interface serializador_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dado_in;
  logic             valido_in;
  logic             pronto_out;
  logic             w;
  logic             bit_valido;
  logic             ocupado;

  modport master (
    output dado_in,
    output valido_in,
    input  pronto_out,
    input  w,
    input  bit_valido,
    input  ocupado
  );

  modport slave (
    input  dado_in,
    input  valido_in,
    output pronto_out,
    output w,
    output bit_valido,
    output ocupado
  );
endinterface

// File: rtl/serializador.sv
// Parallel-to-serial converter with a one-word holding buffer, feeding a serial detector.
// Optional even-parity bit after each word when SERIALIZADOR_PARITY_EN is defined.
module serializador #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  serializador_if.slave bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFT    = 2'd1,
    S_GAP      = 2'd2,
    S_PARIDADE = 2'd3
  } state_t;

  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_cheio;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [3:0]       r_gap;
  logic [3:0]       w_gap_nxt;
  logic             r_w;
  logic             w_w_nxt;
  logic             r_bv;
  logic             w_bv_nxt;
  logic             w_load;
  logic             w_idle_act;
`ifdef SERIALIZADOR_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  // w/bit_valido are computed for the state being entered, so the registered
  // outputs line up with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_w_nxt     = 1'b0;
    w_bv_nxt    = 1'b0;
    w_load      = 1'b0;
    w_idle_act  = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
    w_par_nxt   = r_par;
`endif
    unique case (r_state)
      S_IDLE: w_idle_act = 1'b1;
      S_SHIFT: begin
        if (r_cnt == '0) begin
`ifdef SERIALIZADOR_PARITY_EN
          w_state_nxt = S_PARIDADE;
          w_w_nxt     = r_par;
          w_bv_nxt    = 1'b1;
`else
          if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_LAST;
          end else begin
            w_idle_act = 1'b1;
          end
`endif
        end else begin
          w_sr_nxt  = advance(r_sr);
          w_cnt_nxt = r_cnt - 1'b1;
          w_w_nxt   = head_bit(advance(r_sr));
          w_bv_nxt  = 1'b1;
        end
      end
      S_PARIDADE: begin
        if (GAP > 0) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_LAST;
        end else begin
          w_idle_act = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == 4'd0) begin
          w_idle_act = 1'b1;
        end else begin
          w_gap_nxt = r_gap - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // End of a word (or of its gap) behaves exactly like IDLE in the same cycle.
    if (w_idle_act) begin
      if (r_buf_cheio) begin
        w_load      = 1'b1;
        w_state_nxt = S_SHIFT;
        w_sr_nxt    = r_buf;
        w_cnt_nxt   = LAST_IDX;
        w_w_nxt     = head_bit(r_buf);
        w_bv_nxt    = 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
        w_par_nxt   = ^r_buf;
`endif
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_buf_cheio <= 1'b0;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_gap       <= 4'd0;
      r_w         <= 1'b0;
      r_bv        <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_w     <= w_w_nxt;
      r_bv    <= w_bv_nxt;
`ifdef SERIALIZADOR_PARITY_EN
      r_par   <= w_par_nxt;
`endif
      // A transfer only happens with the buffer full, when no accept is possible.
      if (w_load) begin
        r_buf_cheio <= 1'b0;
      end else if (bus.valido_in && !r_buf_cheio) begin
        r_buf_cheio <= 1'b1;
        r_buf       <= bus.dado_in;
      end
    end
  end

  assign bus.pronto_out = !r_buf_cheio;
  assign bus.w          = r_w;
  assign bus.bit_valido = r_bv;
  assign bus.ocupado    = (r_state != S_IDLE) || r_buf_cheio;

endmodule
